// File: rtl/multi_cycle_control.sv
// Main control FSM of the multi-cycle MIPS core: sequences the shared datapath through
// fetch/decode/execute/memory/write-back, and tracks retired instructions and illegal opcodes.
module multi_cycle_control #(
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] instr_count,
  output logic               illegal
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExec     = 4'd6,
    StRWb      = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StIExec    = 4'd10,
    StIWb      = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpJ     = 6'h02;

  state_e               state_q, state_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 illegal_q, illegal_d;
  logic                 retire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    retire     = 1'b0;
    pc_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 2'b00;

    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        // Speculatively compute the branch target into ALUOut.
        alu_src_b = 2'b11;
        case (opcode)
          OpLw, OpSw:     state_d = StMemAddr;
          OpRtype:        state_d = StExec;
          OpBeq, OpBne:   state_d = StBranch;
          OpAddi, OpAndi: state_d = StIExec;
          OpJ:            state_d = StJump;
          default: begin
            illegal_d = 1'b1;
            state_d   = StFetch;
          end
        endcase
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OpSw) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = StFetch;
      end
      StMemWrite: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = StFetch;
        end
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = StRWb;
      end
      StRWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_source = 2'b01;
        pc_write  = (opcode == OpBeq) ? zero : ~zero;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      StJump: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      StIExec: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (opcode == OpAndi) ? 2'b11 : 2'b00;
        state_d   = StIWb;
      end
      StIWb: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      default: state_d = StFetch;
    endcase

    // State already reads FETCH during reset; only the strobes need suppressing.
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end

    count_d = retire ? count_q + COUNT_W'(1) : count_q;
  end

  assign state       = state_q;
  assign instr_count = count_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Randomized bench for multi_cycle_control: expected state paths are built per instruction
// from opcode and stall counts, and every cycle's control word is checked.
module tb_multi_cycle_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic [31:0] instr_count;
  logic        illegal;
  logic [14:0] obs_ctrl;

  int n_checks = 0;
  int n_pass   = 0;
  int count_m  = 0;
  bit ill_m    = 1'b0;
  int st_q[$];
  bit mr_q[$];

  multi_cycle_control #(.COUNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .mem_to_reg (mem_to_reg),
    .reg_dst    (reg_dst),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_source  (pc_source),
    .state      (state),
    .instr_count(instr_count),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  assign obs_ctrl = {pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
                     reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h02};
  endfunction

  // Control word a state must present, straight from the per-state output table.
  function automatic logic [14:0] exp_ctrl(input int s, input logic [5:0] op, input logic z,
                                           input logic mr);
    logic pw, iod, mrd, mw, irw, m2r, rd, rw, asa;
    logic [1:0] asb, aop, ps;
    {pw, iod, mrd, mw, irw, m2r, rd, rw, asa} = '0;
    {asb, aop, ps} = '0;
    case (s)
      0:  begin mrd = 1; asb = 2'b01; pw = mr; irw = mr; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin iod = 1; mrd = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin iod = 1; mw = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; aop = 2'b01; ps = 2'b01; pw = (op == 6'h04) ? z : ~z; end
      9:  begin ps = 2'b10; pw = 1; end
      10: begin asa = 1; asb = 2'b10; aop = (op == 6'h0C) ? 2'b11 : 2'b00; end
      11: rw = 1;
      default: ;
    endcase
    return {pw, iod, mrd, mw, irw, m2r, rd, rw, asa, asb, aop, ps};
  endfunction

  task automatic push(input int s, input bit mr);
    st_q.push_back(s);
    mr_q.push_back(mr);
  endtask

  task automatic push_wait(input int s, input int stalls);
    repeat (stalls) push(s, 1'b0);
    push(s, 1'b1);
  endtask

  // Run one instruction; abort_state >= 0 asserts rst during the first cycle in that state.
  task automatic run_instr(input logic [5:0] op, input int sf, input int sm,
                           input int abort_state);
    logic [14:0] exp;
    st_q.delete();
    mr_q.delete();
    push_wait(0, sf);
    push(1, 1'($urandom));
    case (op)
      6'h23:        begin push(2, 1'($urandom)); push_wait(3, sm); push(4, 1'($urandom)); end
      6'h2B:        begin push(2, 1'($urandom)); push_wait(5, sm); end
      6'h00:        begin push(6, 1'($urandom)); push(7, 1'($urandom)); end
      6'h04, 6'h05: push(8, 1'($urandom));
      6'h08, 6'h0C: begin push(10, 1'($urandom)); push(11, 1'($urandom)); end
      6'h02:        push(9, 1'($urandom));
      default: ;
    endcase

    for (int i = 0; i < st_q.size(); i++) begin
      opcode    = op;
      mem_ready = mr_q[i];
      zero      = 1'($urandom);
      @(negedge clk);
      exp = exp_ctrl(st_q[i], op, zero, mem_ready);
      check_eq($sformatf("state op=%0h step %0d", op, i), 32'(state), 32'(st_q[i]));
      check_eq($sformatf("ctrl op=%0h st=%0d", op, st_q[i]), 32'(obs_ctrl), 32'(exp));
      check_eq("count_mid", instr_count, 32'(count_m));
      check_eq("illegal_mid", 32'(illegal), 32'(ill_m));
      if (st_q[i] == abort_state) begin
        #1 rst = 1'b1;
        #1;
        count_m = 0;
        ill_m   = 1'b0;
        check_eq("abort_state", 32'(state), 32'd0);
        check_eq("abort_ctrl", 32'(obs_ctrl), 32'h0010);
        check_eq("abort_count", instr_count, 32'd0);
        check_eq("abort_illegal", 32'(illegal), 32'd0);
        mem_ready = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end

    if (is_legal(op)) count_m++;
    else ill_m = 1'b1;
    check_eq($sformatf("end_state op=%0h", op), 32'(state), 32'd0);
    check_eq($sformatf("end_count op=%0h", op), instr_count, 32'(count_m));
    check_eq($sformatf("end_illegal op=%0h", op), 32'(illegal), 32'(ill_m));
  endtask

  logic [5:0] ops [8] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h02};

  initial begin
    logic [5:0] op;
    rst       = 1'b1;
    opcode    = 6'h00;
    zero      = 1'b0;
    mem_ready = 1'b1;
    #3;
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_ctrl", 32'(obs_ctrl), 32'h0010);
    check_eq("rst_count", instr_count, 32'd0);
    check_eq("rst_illegal", 32'(illegal), 32'd0);
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_instr(6'h23, 0, 0, -1);
    run_instr(6'h04, 0, 0, -1);
    run_instr(6'h04, 1, 0, -1);
    run_instr(6'h2B, 0, 3, -1);
    run_instr(6'h3F, 0, 0, -1);
    run_instr(6'h08, 0, 0, -1);
    run_instr(6'h0C, 2, 0, -1);
    run_instr(6'h02, 0, 0, -1);
    run_instr(6'h05, 0, 0, -1);
    run_instr(6'h00, 0, 0, -1);
    run_instr(6'h23, 2, 2, -1);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(7) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(7)];
      run_instr(op, $urandom_range(3), $urandom_range(3), -1);
    end

    run_instr(6'h00, 1, 0, 6);
    run_instr(6'h23, 0, 1, -1);
    run_instr(6'h04, 0, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
